// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: instruction size and the layout of one fetch-queue entry.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Queue entries are packed {pc, instr}; fetch_unit builds the same layout at width NBITS.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with first-word fall-through head and a
// single-cycle clear that takes priority over push and pop.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count/pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request stream to instruction memory, in-order
// response queue, and redirect flush that drops responses still in flight.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               NBITS    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [NBITS-1:0] redirect_pc,
  output logic             imem_req,
  output logic [NBITS-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [NBITS-1:0] imem_rdata,
  output logic             out_valid,
  output logic [NBITS-1:0] out_instr,
  output logic [NBITS-1:0] out_pc,
  input  logic             out_ready
);

  localparam int               CW      = $clog2(DEPTH+1);
  localparam int               ENTRY_W = 2 * NBITS;
  localparam logic [NBITS-1:0] PC_STEP = NBITS'(INSTR_BYTES);
  localparam logic [CW:0]      CREDITS = (CW+1)'(DEPTH);

  logic [NBITS-1:0]   r_fetch_pc;
  logic [NBITS-1:0]   r_resp_pc;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_drop;

  logic               w_redirect;
  logic [NBITS-1:0]   w_redirect_pc;
  logic               w_credit;
  logic               w_grant;
  logic               w_rsp;
  logic               w_accept;
  logic               w_pop;
  logic [CW-1:0]      w_inflight_nxt;
  logic [CW-1:0]      w_drop_nxt;
  logic [CW-1:0]      w_occupancy;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;

  // Handshakes: a request transfers when imem_req && imem_gnt in the same cycle;
  // each imem_rvalid returns exactly one earlier grant, in order; the queue head
  // transfers when out_valid && out_ready. No side may retract or reorder.

  assign w_redirect    = redirect_valid && !rst;
  assign w_redirect_pc = redirect_pc & ~(NBITS'(INSTR_BYTES - 1));

  // Every slot that could receive a response is reserved at grant time, so the
  // queue can never overflow.
  assign w_credit  = ({1'b0, w_occupancy} + {1'b0, r_inflight}) < CREDITS;
  assign imem_req  = !rst && !redirect_valid && w_credit;
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;

  assign w_rsp    = imem_rvalid && !rst && (r_inflight != '0);
  assign w_accept = w_rsp && (r_drop == '0) && !redirect_valid && !w_full;
  assign w_pop    = out_ready && !w_empty && !redirect_valid;

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_grant && !w_rsp)      w_inflight_nxt = r_inflight + CW'(1);
    else if (!w_grant && w_rsp) w_inflight_nxt = r_inflight - CW'(1);
  end

  // On redirect every response not returning this cycle belongs to the old path.
  always_comb begin
    w_drop_nxt = r_drop;
    if (w_redirect)                  w_drop_nxt = w_rsp ? (r_inflight - CW'(1)) : r_inflight;
    else if (w_rsp && r_drop != '0)  w_drop_nxt = r_drop - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
      end else begin
        if (w_grant)  r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_accept) r_resp_pc  <= r_resp_pc + PC_STEP;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_pop),
    .clear (w_redirect),
    .wdata ({r_resp_pc, imem_rdata}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_occupancy)
  );

  assign out_valid = !w_empty;
  assign out_pc    = w_head[ENTRY_W-1:NBITS];
  assign out_instr = w_head[NBITS-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency, PC model and
// expected-fetch queue, directed scenarios followed by a random run.
module tb_fetch_unit;

  localparam int          NBITS    = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] pend_addr[$];
  longint      pend_due[$];
  logic [31:0] model_pc = RESET_PC;
  longint      cyc = 0;
  int          mem_lat = 1;
  int          gnt_pct = 100;
  int          grant_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .NBITS    (NBITS),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a ^ 32'hDEAD_BEEF) + 32'h0000_1357;
  endfunction

  // Instruction memory: answers grants in order, each no earlier than its due cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
  end

  // Scoreboard: the PC model predicts every granted address; pops are checked in order.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_pop: got pc=%h with no expected entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e || out_instr !== instr_of(e)) begin
            failures++;
            $display("FAIL sb_pop: got pc=%h instr=%h expected pc=%h instr=%h",
                     out_pc, out_instr, e, instr_of(e));
          end
        end
        pop_log.push_back(out_pc);
      end
      if (imem_req && imem_gnt) begin
        checks++;
        if (imem_addr !== model_pc) begin
          failures++;
          $display("FAIL sb_addr: got imem_addr=%h expected %h", imem_addr, model_pc);
        end
        exp_q.push_back(model_pc);
        pend_addr.push_back(model_pc);
        pend_due.push_back(cyc + longint'(mem_lat));
        model_pc = model_pc + 32'd4;
        grant_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first;
    first = -1;
    out_ready = 1'b1; mem_lat = 1; gnt_pct = 100;
    tick(); rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    tick(); rst = 1'b0; pop_log.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
          failures++;
          $display("FAIL rst_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
      end
      if (out_valid === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != 2) begin failures++; $display("FAIL rst_latency: got first out_valid at %0d expected 2", first); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
        failures++;
        $display("FAIL rst_seq: pop %0d wrong or missing, expected pc=%h", i, 32'(i * 4));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; mem_lat = 1; gnt_pct = 100;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; grant_cnt = 0; pop_log.delete();
    repeat (10) @(negedge clk);
    checks++;
    if (grant_cnt != DEPTH) begin failures++; $display("FAIL bp_grants: got %0d expected %0d", grant_cnt, DEPTH); end
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b expected 0", imem_req); end
    checks++;
    if (dut.w_occupancy !== 3'd4) begin failures++; $display("FAIL bp_occ: got %0d expected 4", dut.w_occupancy); end
    tick(); out_ready = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
        failures++;
        $display("FAIL bp_seq: pop %0d wrong or missing, expected pc=%h", i, 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_drop();
    int wait_k;
    wait_k = -1;
    out_ready = 1'b1; mem_lat = 3; gnt_pct = 100;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rd_req: got %b expected 0 in redirect cycle", imem_req); end
    tick(); redirect_valid = 1'b0; pop_log.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("FAIL rd_addr: got %h expected 00000100", imem_addr); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin wait_k = k; break; end
    end
    checks++;
    if (wait_k != 3) begin failures++; $display("FAIL rd_wait: got %0d expected 3", wait_k); end
    checks++;
    if (out_pc !== 32'h100 || out_instr !== instr_of(32'h100)) begin
      failures++;
      $display("FAIL rd_head: got pc=%h instr=%h expected pc=00000100 instr=%h", out_pc, out_instr, instr_of(32'h100));
    end
  endtask

  task automatic test_redirect_same_cycle();
    out_ready = 1'b1; mem_lat = 1; gnt_pct = 100;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; pop_log.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rs_pre: got out_valid=%b expected 1", out_valid); end
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rs_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      failures++;
      $display("FAIL rs_addr: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h2000) begin failures++; $display("FAIL rs_first: first pop not pc=00002000"); end
  endtask

  task automatic test_reset_midop();
    bit seen;
    seen = 1'b0;
    out_ready = 1'b0; mem_lat = 3; gnt_pct = 100;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dut.w_occupancy === 3'd4) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rm_fill: got occupancy=%0d expected 4", dut.w_occupancy); end
    tick(); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_req: got %b expected 0", imem_req); end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    tick(); rst = 1'b0; out_ready = 1'b1; pop_log.delete();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rm_restart: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== RESET_PC) begin failures++; $display("FAIL rm_first: first pop not pc=%h", RESET_PC); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; mem_lat = 1; gnt_pct = 100;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; pop_log.delete();
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got %h expected fffffffc", imem_addr); end
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h expected 00000000", imem_addr); end
    repeat (4) @(negedge clk);
    checks++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_seq: pops not fffffffc then 00000000 (count %0d)", pop_log.size());
    end
  endtask

  task automatic test_random();
    int n0;
    gnt_pct = 70;
    for (int i = 0; i < 400; i++) begin
      tick();
      out_ready      = ($urandom_range(0, 3) != 0);
      mem_lat        = int'($urandom_range(1, 4));
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
    end
    tick(); redirect_valid = 1'b0; out_ready = 1'b1; gnt_pct = 100; mem_lat = 1;
    n0 = pop_log.size();
    repeat (30) tick();
    checks++;
    if (pop_log.size() < n0 + 20) begin
      failures++;
      $display("FAIL rnd_drain: got %0d pops expected at least 20", pop_log.size() - n0);
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_backpressure();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
